// File: rtl/nf10_axis_sim_stim.sv
// AXI4-Stream packet generator: bursts of deterministic-payload packets with
// NetFPGA tuser metadata, honouring tready backpressure.
module nf10_axis_sim_stim #(
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_IFG_CYCLES         = 0
) (
  input  logic                                aclk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [15:0]                         pkt_len,
  input  logic [15:0]                         pkt_count,
  input  logic [7:0]                          src_port,
  input  logic [7:0]                          dst_port,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic                                m_axis_tlast,
  output logic [7:0]                          counter,
  output logic                                activity_stim,
  output logic                                done
);

  localparam int unsigned DW = C_M_AXIS_DATA_WIDTH;
  localparam int unsigned SW = C_M_AXIS_DATA_WIDTH / 8;
  localparam int unsigned UW = C_M_AXIS_TUSER_WIDTH;
  localparam logic [7:0] IFG_LOAD = (C_IFG_CYCLES == 0) ? 8'd0 : 8'(C_IFG_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  // Build the full beat at index idx of a packet of len bytes.
  function automatic beat_t make_beat(input logic [15:0] idx, input logic [15:0] len,
                                      input logic [7:0] src, input logic [7:0] dst);
    beat_t      b;
    logic [21:0] end_byte;
    logic [4:0]  rem;
    b        = '0;
    end_byte = 22'({idx, 5'd0}) + 22'd32;
    rem      = len[4:0];
    b.last   = (end_byte >= 22'(len));
    if (b.last && rem != 5'd0) b.strb = ~({SW{1'b1}} << rem);
    else                       b.strb = '1;
    for (int unsigned l = 0; l < SW; l++) begin
      if (b.strb[l]) b.data[8*l +: 8] = {idx[2:0], 5'(l)};
    end
    if (idx == 16'd0) b.user[31:0] = {dst, src, len};
    return b;
  endfunction

  state_t      state_q, state_d;
  beat_t       beat_q, beat_d;
  logic        valid_q, valid_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] sent_q, sent_d;
  logic [7:0]  counter_q, counter_d;
  logic [7:0]  gap_q, gap_d;
  logic [15:0] len_q, len_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  src_q, src_d;
  logic [7:0]  dst_q, dst_d;
  logic        done_q, done_d;
  logic        act_q, act_d;
  logic        hs_c;

  assign hs_c = valid_q & m_axis_tready;

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      sent_q    <= '0;
      counter_q <= '0;
      gap_q     <= '0;
      len_q     <= '0;
      count_q   <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      done_q    <= 1'b0;
      act_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      sent_q    <= sent_d;
      counter_q <= counter_d;
      gap_q     <= gap_d;
      len_q     <= len_d;
      count_q   <= count_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      done_q    <= done_d;
      act_q     <= act_d;
    end
  end

  // Next-state logic; the next beat is precomputed so every output is a flop.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    valid_d   = valid_q;
    idx_d     = idx_q;
    sent_d    = sent_q;
    counter_d = counter_q;
    gap_d     = gap_q;
    len_d     = len_q;
    count_d   = count_q;
    src_d     = src_q;
    dst_d     = dst_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && pkt_len != 16'd0 && pkt_count != 16'd0) begin
          len_d     = pkt_len;
          count_d   = pkt_count;
          src_d     = src_port;
          dst_d     = dst_port;
          counter_d = '0;
          idx_d     = '0;
          sent_d    = '0;
          state_d   = SEND;
          valid_d   = 1'b1;
          beat_d    = make_beat(16'd0, pkt_len, src_port, dst_port);
        end
      end
      SEND: begin
        if (hs_c) begin
          if (beat_q.last) begin
            counter_d = counter_q + 8'd1;
            sent_d    = sent_q + 16'd1;
            idx_d     = '0;
            if (17'(sent_q) + 17'd1 < 17'(count_q)) begin
              if (C_IFG_CYCLES == 0) begin
                beat_d = make_beat(16'd0, len_q, src_q, dst_q);
              end else begin
                state_d = GAP;
                gap_d   = IFG_LOAD;
                valid_d = 1'b0;
                beat_d  = '0;
              end
            end else begin
              state_d = IDLE;
              valid_d = 1'b0;
              beat_d  = '0;
              done_d  = 1'b1;
            end
          end else begin
            idx_d  = idx_q + 16'd1;
            beat_d = make_beat(idx_q + 16'd1, len_q, src_q, dst_q);
          end
        end
      end
      GAP: begin
        if (gap_q == 8'd0) begin
          state_d = SEND;
          valid_d = 1'b1;
          beat_d  = make_beat(16'd0, len_q, src_q, dst_q);
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    act_d = (state_d != IDLE);
  end

  assign m_axis_tdata  = beat_q.data;
  assign m_axis_tstrb  = beat_q.strb;
  assign m_axis_tuser  = beat_q.user;
  assign m_axis_tlast  = beat_q.last;
  assign m_axis_tvalid = valid_q;
  assign counter       = counter_q;
  assign activity_stim = act_q;
  assign done          = done_q;

endmodule

// File: tb/tb_nf10_axis_sim_stim.sv
// Bench for nf10_axis_sim_stim: two instances (no gap, 3-cycle gap) share the
// stimulus; each is compared every cycle against a byte-level packet model.
module tb_nf10_axis_sim_stim;

  localparam int IFG1 = 3;

  logic        aclk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] pkt_len = '0;
  logic [15:0] pkt_count = '0;
  logic [7:0]  src_port = '0;
  logic [7:0]  dst_port = '0;
  logic        tready = 1'b1;

  logic [255:0] tdata  [2];
  logic [31:0]  tstrb  [2];
  logic [127:0] tuser  [2];
  logic         tvalid [2];
  logic         tlast  [2];
  logic [7:0]   ctr    [2];
  logic         act    [2];
  logic         done   [2];

  always #5 aclk = ~aclk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    nf10_axis_sim_stim #(
      .C_M_AXIS_DATA_WIDTH (256),
      .C_M_AXIS_TUSER_WIDTH(128),
      .C_IFG_CYCLES        (g * IFG1)
    ) dut (
      .aclk         (aclk),
      .reset        (reset),
      .start        (start),
      .pkt_len      (pkt_len),
      .pkt_count    (pkt_count),
      .src_port     (src_port),
      .dst_port     (dst_port),
      .m_axis_tdata (tdata[g]),
      .m_axis_tstrb (tstrb[g]),
      .m_axis_tuser (tuser[g]),
      .m_axis_tvalid(tvalid[g]),
      .m_axis_tready(tready),
      .m_axis_tlast (tlast[g]),
      .counter      (ctr[g]),
      .activity_stim(act[g]),
      .done         (done[g])
    );
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected beat from byte-level rules: byte k of the packet is k mod 256.
  function automatic logic [416:0] exp_beat(input int len, input int idx,
                                            input logic [7:0] src, input logic [7:0] dst);
    logic [255:0] d = '0;
    logic [31:0]  s = '0;
    logic [127:0] u = '0;
    logic         l;
    int           b;
    for (int k = 0; k < 32; k++) begin
      b = idx * 32 + k;
      if (b < len) begin
        d[k*8 +: 8] = b[7:0];
        s[k] = 1'b1;
      end
    end
    l = (len - idx * 32) <= 32;
    if (idx == 0) u[31:0] = {dst, src, 16'(len)};
    return {d, s, u, l};
  endfunction

  // Model state per instance
  bit         m_init = 0;
  bit         m_busy [2];
  bit         m_done [2];
  bit         m_rst  [2];
  int         m_gap  [2];
  int         m_beat [2];
  int         m_pkt  [2];
  int         m_len  [2];
  int         m_cnt  [2];
  logic [7:0] m_src  [2];
  logic [7:0] m_dst  [2];
  logic [7:0] m_ctr  [2];
  int         obs_tl [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_done[i] = 0; m_rst[i] = 0; m_gap[i] = 0; m_beat[i] = 0;
      m_pkt[i] = 0; m_len[i] = 0; m_cnt[i] = 0; m_src[i] = '0; m_dst[i] = '0;
      m_ctr[i] = '0; obs_tl[i] = 0;
    end
    forever begin
      @(negedge aclk);
      for (int i = 0; i < 2; i++) begin
        logic [416:0] e;
        bit           ve;
        int           gcyc;
        gcyc = (i == 0) ? 0 : IFG1;
        ve   = m_busy[i] && m_gap[i] == 0;
        e    = exp_beat(m_len[i], m_beat[i], m_src[i], m_dst[i]);
        if (m_init) begin
          check($sformatf("d%0d_valid", i), 512'(tvalid[i]), 512'(ve));
          check($sformatf("d%0d_activity", i), 512'(act[i]), 512'(m_busy[i]));
          check($sformatf("d%0d_done", i), 512'(done[i]), 512'(m_done[i]));
          check($sformatf("d%0d_counter", i), 512'(ctr[i]), 512'(m_ctr[i]));
          if (ve)
            check($sformatf("d%0d_beat%0d", i, m_beat[i]),
                  512'({tdata[i], tstrb[i], tuser[i], tlast[i]}), 512'(e));
          else if (m_rst[i])
            check($sformatf("d%0d_rst_beat", i),
                  512'({tdata[i], tstrb[i], tuser[i], tlast[i]}), 512'(0));
        end
        if (tvalid[i] === 1'b1 && tlast[i] === 1'b1 && tready) obs_tl[i]++;
        m_done[i] = 0;
        m_rst[i]  = 0;
        if (reset) begin
          m_busy[i] = 0; m_gap[i] = 0; m_beat[i] = 0; m_pkt[i] = 0; m_ctr[i] = '0;
          m_rst[i] = 1;
        end else if (m_busy[i]) begin
          if (m_gap[i] > 0) m_gap[i]--;
          else if (tready) begin
            if (e[0]) begin
              m_ctr[i]++;
              m_pkt[i]++;
              m_beat[i] = 0;
              if (m_pkt[i] == m_cnt[i]) begin
                m_busy[i] = 0;
                m_done[i] = 1;
              end else m_gap[i] = gcyc;
            end else m_beat[i]++;
          end
        end else if (start && pkt_len != 0 && pkt_count != 0) begin
          m_busy[i] = 1; m_gap[i] = 0; m_beat[i] = 0; m_pkt[i] = 0; m_ctr[i] = '0;
          m_len[i] = int'(pkt_len); m_cnt[i] = int'(pkt_count);
          m_src[i] = src_port; m_dst[i] = dst_port;
        end
      end
      if (reset) m_init = 1;
    end
  end

  // tready pattern: 0 = always ready, 1 = 1,0,0 repeating, 2 = random
  int rdy_mode = 0;
  initial begin
    int cyc = 0;
    forever begin
      @(posedge aclk);
      #1;
      case (rdy_mode)
        1:       tready = (cyc % 3 == 0);
        2:       tready = ($urandom_range(0, 3) != 0);
        default: tready = 1'b1;
      endcase
      cyc++;
    end
  end

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic do_start(input int len, input int cnt, input logic [7:0] src, input logic [7:0] dst);
    tick;
    start = 1'b1;
    pkt_len = 16'(len);
    pkt_count = 16'(cnt);
    src_port = src;
    dst_port = dst;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((m_busy[0] || m_busy[1]) && n < budget) begin
      tick;
      n++;
    end
    if (n >= budget) check("idle_timeout", 512'(1), 512'(0));
    repeat (3) tick;
  endtask

  initial begin
    repeat (3) tick;
    reset = 1'b0;
    repeat (2) tick;

    // single beat
    rdy_mode = 0;
    do_start(20, 1, 8'h11, 8'h22);
    wait_idle(50);
    check("single_ctr0", 512'(ctr[0]), 512'(1));
    check("single_ctr1", 512'(ctr[1]), 512'(1));

    // multi-beat with backpressure
    rdy_mode = 1;
    do_start(64, 2, 8'h03, 8'h04);
    wait_idle(200);
    check("multi_ctr1", 512'(ctr[1]), 512'(2));

    // gapped, odd length
    rdy_mode = 0;
    do_start(33, 3, 8'h05, 8'h06);
    wait_idle(200);

    // illegal starts
    do_start(0, 5, 8'h07, 8'h08);
    do_start(5, 0, 8'h07, 8'h08);
    repeat (10) tick;
    check("illegal_ctr0", 512'(ctr[0]), 512'(3));

    // start while busy
    do_start(100, 2, 8'hA0, 8'hB0);
    tick;
    start = 1'b1; pkt_len = 16'd7; pkt_count = 16'd9; src_port = 8'hEE; dst_port = 8'hFF;
    tick;
    start = 1'b0;
    wait_idle(300);
    check("busy_ctr0", 512'(ctr[0]), 512'(2));

    // reset during beat 2 of a 4-beat packet
    do_start(128, 1, 8'h01, 8'h02);
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tick;
    check("rst_ctr0", 512'(ctr[0]), 512'(0));
    do_start(40, 1, 8'h09, 8'h0A);
    wait_idle(100);

    // randomized traffic
    for (int t = 0; t < 8; t++) begin
      rdy_mode = $urandom_range(0, 2);
      do_start($urandom_range(1, 200), $urandom_range(1, 4),
               8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      wait_idle(2000);
    end

    // counter wrap
    rdy_mode = 0;
    repeat (2) tick;
    obs_tl[0] = 0;
    obs_tl[1] = 0;
    do_start(1, 257, 8'h33, 8'h44);
    wait_idle(3000);
    check("wrap_tlast0", 512'(obs_tl[0]), 512'(257));
    check("wrap_tlast1", 512'(obs_tl[1]), 512'(257));
    check("wrap_ctr0", 512'(ctr[0]), 512'(1));
    check("wrap_ctr1", 512'(ctr[1]), 512'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
